// File: rtl/res_tx_enc_pkg.sv
// Shared key-code package for the calculator UART path.
// Holds the 4-bit key-code map used by the inbound key decoder and by the
// result encoder, plus the encoder FSM state type.
package res_tx_enc_pkg;

    // Key-code map: 0x0-0x9 are decimal digits
    localparam logic [3:0] CODE_MINUS = 4'hB;
    localparam logic [3:0] CODE_ENTER = 4'hE;
    localparam logic [3:0] CODE_ERR   = 4'hF;
    localparam logic [3:0] DIGIT_MAX  = 4'h9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONV    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/res_tx_enc_if.sv
// Bus between the calculator core / UART transmitter and the result encoder.
// master: the core and transmitter side (drives start/result/err/tx_busy)
// slave : the encoder (drives tx_data/tx_start/busy/done)
interface res_tx_enc_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] result;
    logic              err;
    logic              tx_busy;
    logic [3:0]        tx_data;
    logic              tx_start;
    logic              busy;
    logic              done;

    modport master (
        output start, result, err, tx_busy,
        input  tx_data, tx_start, busy, done
    );

    modport slave (
        input  start, result, err, tx_busy,
        output tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/res_tx_enc_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports: clk, rst_n (async active-low), go (load bin and start),
//        bin (unsigned magnitude), bcd (NDIG packed BCD digits),
//        valid (1-clk pulse once all DATA_W shift steps are done).
// The first shift step happens on the go edge itself, so valid rises
// DATA_W-1 edges after go.
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int NDIG   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [DATA_W-1:0]   bin,
    output logic [4*NDIG-1:0]   bcd,
    output logic                valid
);
    localparam int ACC_W = 4*NDIG + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic             valid_r;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
    function automatic logic [ACC_W-1:0] dd_step(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] t;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            if (t[DATA_W+4*i +: 4] >= 4'd5) begin
                t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
            end
        end
        return {t[ACC_W-2:0], 1'b0};
    endfunction

    // Shift/convert register and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            cnt_r   <= '0;
            run_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (go) begin
                acc_r <= dd_step({{(4*NDIG){1'b0}}, bin});
                cnt_r <= CNT_W'(DATA_W - 1);
                run_r <= 1'b1;
            end else if (run_r) begin
                acc_r <= dd_step(acc_r);
                cnt_r <= cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    run_r   <= 1'b0;
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign bcd   = acc_r[ACC_W-1 -: 4*NDIG];
    assign valid = valid_r;

endmodule

// File: rtl/res_tx_enc.sv
// Result encoder: converts a signed calculator result into a key-code
// sequence ([B] digits E, or F E on error) and sends it one code per UART
// frame.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   start/result/err from the core, tx_busy from the transmitter,
//   tx_data/tx_start to the transmitter, busy/done status to the core.
module res_tx_enc
    import res_tx_enc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NDIG   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    res_tx_enc_if.slave   bus
);
    localparam int IDX_W = $clog2(NDIG + 2);

    state_t                 state_r, next_s;
    logic                   neg_r;
    logic [NDIG+1:0][3:0]   q_r, q_s;
    logic [IDX_W-1:0]       idx_r, last_r, last_s;
    logic [DATA_W-1:0]      mag_s;
    logic [4*NDIG-1:0]      bcd_s;
    logic                   valid_s;
    logic                   go_s;
    logic [3:0]             tx_data_r, tx_data_s;
    logic                   tx_start_r, tx_start_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;

    // Most negative value maps onto 2^(DATA_W-1), which still fits unsigned
    assign mag_s = bus.result[DATA_W-1] ? (~bus.result + DATA_W'(1)) : bus.result;
    assign go_s  = (state_r == S_IDLE) && bus.start && !bus.err;

    bin2bcd_seq #(.DATA_W(DATA_W), .NDIG(NDIG)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go_s),
        .bin   (mag_s),
        .bcd   (bcd_s),
        .valid (valid_s)
    );

    // Queue builder: optional sign, digits without leading zeros, then enter
    always_comb begin
        logic [IDX_W-1:0] n_v;
        logic             started_v;
        logic [3:0]       d_v;
        q_s       = '0;
        n_v       = '0;
        started_v = 1'b0;
        if (neg_r) begin
            q_s[0] = CODE_MINUS;
            n_v    = IDX_W'(1);
        end else begin
            n_v    = '0;
        end
        for (int i = NDIG - 1; i >= 0; i--) begin
            d_v = bcd_s[4*i +: 4];
            // Units digit always goes out so a zero result reads "0"
            if (d_v != 4'h0 || started_v || i == 0) begin
                q_s[n_v]  = d_v;
                n_v       = n_v + IDX_W'(1);
                started_v = 1'b1;
            end else begin
                started_v = started_v;
            end
        end
        q_s[n_v] = CODE_ENTER;
        last_s   = n_v;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE:    if (bus.start) next_s = bus.err ? S_ISSUE : S_CONV;
                       else           next_s = S_IDLE;
            S_CONV:    if (valid_s)   next_s = S_ISSUE;
                       else           next_s = S_CONV;
            S_ISSUE:   if (!bus.tx_busy) next_s = S_WAIT_HI;
                       else              next_s = S_ISSUE;
            S_WAIT_HI: if (bus.tx_busy)  next_s = S_WAIT_LO;
                       else              next_s = S_WAIT_HI;
            S_WAIT_LO: if (!bus.tx_busy) next_s = (idx_r == last_r) ? S_DONE : S_ISSUE;
                       else              next_s = S_WAIT_LO;
            S_DONE:    next_s = S_IDLE;
            default:   next_s = S_IDLE;
        endcase
    end

    // FSM output logic (next values of the registered outputs)
    always_comb begin
        tx_start_s = (state_r == S_ISSUE) && !bus.tx_busy;
        if (tx_start_s) begin
            tx_data_s = q_r[idx_r];
        end else begin
            tx_data_s = tx_data_r;
        end
        busy_s = (next_s == S_CONV) || (next_s == S_ISSUE) ||
                 (next_s == S_WAIT_HI) || (next_s == S_WAIT_LO);
        done_s = (next_s == S_DONE);
    end

    // Code queue, sign latch and queue index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r  <= 1'b0;
            q_r    <= '0;
            idx_r  <= '0;
            last_r <= '0;
        end else begin
            if (state_r == S_IDLE && bus.start) begin
                neg_r <= bus.result[DATA_W-1];
                idx_r <= '0;
                if (bus.err) begin
                    q_r    <= '0;
                    q_r[0] <= CODE_ERR;
                    q_r[1] <= CODE_ENTER;
                    last_r <= IDX_W'(1);
                end
            end else if (state_r == S_CONV && valid_s) begin
                q_r    <= q_s;
                last_r <= last_s;
                idx_r  <= '0;
            end else if (state_r == S_WAIT_LO && !bus.tx_busy && idx_r != last_r) begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r  <= 4'h0;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bus.tx_data  = tx_data_r;
    assign bus.tx_start = tx_start_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_res_tx_enc.sv
// Self-checking bench for res_tx_enc: table of results with expected code
// sequences and first-tx_start latency, plus hand-written sequences for a
// stalled transmitter with slow busy rise and for reset mid-sequence.
module tb_res_tx_enc;

    typedef struct {
        logic [15:0] result;
        logic        err;
        int          n;
        logic [27:0] seq;   // codes in send order, first code in top nibble
        int          lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    res_tx_enc_if #(.DATA_W(16)) bus();

    logic mdl_busy = 1'b0;
    logic ext_busy = 1'b0;
    assign bus.tx_busy = mdl_busy | ext_busy;

    res_tx_enc #(.DATA_W(16), .NDIG(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int rise_dly  = 1;
    int frame_len = 4;
    int rise_cnt  = 0;
    int hold_cnt  = 0;
    int last_fall = 0;
    int viol      = 0;
    int dup       = 0;
    logic prev_start = 1'b0;
    logic [3:0] codes[$];
    int start_cyc[$];
    int done_q[$];

    vec_t vecs[9];

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model and monitor, on the falling edge
    always @(negedge clk) begin
        if (bus.tx_start) begin
            if (bus.tx_busy) viol++;
            if (prev_start)  dup++;
            codes.push_back(bus.tx_data);
            start_cyc.push_back(cyc);
        end
        if (bus.done) done_q.push_back(cyc);
        prev_start = bus.tx_start;
        if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) begin
                mdl_busy  = 1'b0;
                last_fall = cyc;
            end
        end
        if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                mdl_busy = 1'b1;
                hold_cnt = frame_len;
            end
        end
        if (bus.tx_start) begin
            if (rise_dly == 0) begin
                mdl_busy = 1'b1;
                hold_cnt = frame_len;
            end else begin
                rise_cnt = rise_dly;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int dbase, input string name);
        int guard = 0;
        while (done_q.size() == dbase && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_done_seen"}, 32'(done_q.size() > dbase), 32'd1);
    endtask

    task automatic check_codes(input vec_t v, input int base, input string name);
        logic [3:0]  exp_c;
        logic [31:0] act_c;
        check({name, "_code_count"}, 32'(codes.size() - base), 32'(v.n));
        for (int i = 0; i < v.n; i++) begin
            exp_c = v.seq[27-4*i -: 4];
            act_c = (base + i < codes.size()) ? 32'(codes[base+i]) : 32'hDEAD;
            check($sformatf("%s_code%0d", name, i), act_c, 32'(exp_c));
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int base, sbase, dbase, c0;
        base  = codes.size();
        sbase = start_cyc.size();
        dbase = done_q.size();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.result = v.result;
        bus.err    = v.err;
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        check({name, "_busy_set"}, 32'(bus.busy), 32'd1);
        wait_done(dbase, name);
        repeat (4) @(negedge clk);
        check_codes(v, base, name);
        check({name, "_latency"},
              (start_cyc.size() > sbase) ? 32'(start_cyc[sbase] - c0) : 32'hDEAD, 32'(v.lat));
        check({name, "_done_once"}, 32'(done_q.size() - dbase), 32'd1);
        check({name, "_done_after_fall"},
              (done_q.size() > dbase) ? 32'(done_q[dbase] - last_fall) : 32'hDEAD, 32'd1);
        check({name, "_busy_clear"}, 32'(bus.busy), 32'd0);
        check({name, "_no_viol"}, 32'(viol + dup), 32'd0);
    endtask

    initial begin
        int base, dbase, guard;
        vec_t v;
        bus.start  = 1'b0;
        bus.result = 16'h0000;
        bus.err    = 1'b0;

        vecs[0] = '{16'h0000, 1'b0, 2, 28'h0E00000, 18};
        vecs[1] = '{16'h007B, 1'b0, 4, 28'h123E000, 18};
        vecs[2] = '{16'hFFD3, 1'b0, 4, 28'hB45E000, 18};
        vecs[3] = '{16'h8000, 1'b0, 7, 28'hB32768E, 18};
        vecs[4] = '{16'h1234, 1'b1, 2, 28'hFE00000, 2};
        vecs[5] = '{16'h7FFF, 1'b0, 6, 28'h32767E0, 18};
        vecs[6] = '{16'h000A, 1'b0, 3, 28'h10E0000, 18};
        vecs[7] = '{16'hFFFF, 1'b0, 3, 28'hB1E0000, 18};
        vecs[8] = '{16'h0007, 1'b0, 2, 28'h7E00000, 18};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.tx_data, bus.tx_start, bus.busy, bus.done}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stalled transmitter, slow busy rise, start while busy ignored
        rise_dly  = 3;
        frame_len = 5;
        base  = codes.size();
        dbase = done_q.size();
        @(negedge clk);
        ext_busy   = 1'b1;
        bus.start  = 1'b1;
        bus.result = 16'd123;
        bus.err    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        bus.start  = 1'b1;
        bus.result = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_no_start", 32'(codes.size() - base), 32'd0);
        ext_busy = 1'b0;
        wait_done(dbase, "stall");
        repeat (30) @(negedge clk);
        v = vecs[1];
        check_codes(v, base, "stall");
        check("stall_done_once", 32'(done_q.size() - dbase), 32'd1);
        check("stall_no_viol", 32'(viol), 32'd0);
        check("stall_no_dup", 32'(dup), 32'd0);

        // Reset during WAIT_LO of the second code of 123
        rise_dly  = 1;
        frame_len = 6;
        base = codes.size();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.result = 16'd123;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (codes.size() < base + 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_two_codes", 32'(codes.size() - base), 32'd2);
        repeat (3) @(negedge clk);
        check("rst_pre_data", 32'(bus.tx_data), 32'h2);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {bus.tx_data, bus.tx_start, bus.busy, bus.done}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_no_more_start", 32'(codes.size() - base), 32'd2);
        run_vec(vecs[8], "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
